// File: rtl/timer_irq_source.sv
// timer_irq_source: memory-mapped down-counting timer that drives one
// interrupt request line.
//
// Ports:
//   clk    in           system clock, all state updates on the rising edge
//   reset  in           synchronous active-high reset, clears all state
//   addr   in  [1:0]    word select: 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved
//   we     in           write enable, sampled on the rising edge
//   din    in  [W-1:0]  write data
//   dout   out [W-1:0]  read data, combinational from addr
//   irq    out          interrupt request, flag & IM (driven from flops only)
//
// CTRL layout: bit0 En, bits2:1 Mode (01 = auto-reload, others one-shot),
// bit3 IM. Upper CTRL bits are not stored and read back as 0.
module timer_irq_source #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             irq
);

  localparam int unsigned CTRL_W = 4;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_e;

  state_e              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [WIDTH-1:0]    preset_q, preset_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                flag_q, flag_d;

  logic                en;
  logic                im;
  logic                auto_reload;

  assign en          = ctrl_q[0];
  assign im          = ctrl_q[3];
  assign auto_reload = (ctrl_q[2:1] == MODE_RELOAD);

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state: timer sequencing first, bus writes applied last so they win
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= WIDTH'(1)) begin
          // Preset 0 and 1 both expire after a single counting cycle
          count_d = '0;
          flag_d  = 1'b1;
          state_d = ST_INT;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
      ST_INT: begin
        if (auto_reload) begin
          flag_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          ctrl_d = din[CTRL_W-1:0];
          flag_d = 1'b0;
        end
        ADDR_PRESET: begin
          preset_d = din;
          flag_d   = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Read mux
  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = WIDTH'(ctrl_q);
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = flag_q & im;

endmodule

// File: tb/tb_timer_irq_source.sv
// tb_timer_irq_source: directed scenarios with literal expectations followed
// by randomized bus traffic, all checked against a behavioural timer model.
module tb_timer_irq_source;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             irq;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  timer_irq_source #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_LOAD, M_CNT, M_INT} mphase_e;

  mphase_e     m_phase;
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  bit          m_flag;

  function automatic void model_step(input bit rst, input bit w, input logic [1:0] a,
                                     input logic [31:0] d);
    mphase_e     np;
    logic [3:0]  nc;
    logic [31:0] ncount;
    bit          nflag;
    if (rst) begin
      m_phase = M_IDLE; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 0;
      return;
    end
    np = m_phase; nc = m_ctrl; ncount = m_count; nflag = m_flag;
    if (m_phase == M_IDLE) begin
      np = m_ctrl[0] ? M_LOAD : M_IDLE;
    end else if (m_phase == M_LOAD) begin
      ncount = m_preset;
      np = M_CNT;
    end else if (m_phase == M_CNT) begin
      if (m_ctrl[0] == 1'b0) np = M_IDLE;
      else if (m_count <= 32'd1) begin ncount = 32'd0; nflag = 1; np = M_INT; end
      else ncount = m_count - 32'd1;
    end else begin
      if (m_ctrl[2:1] == 2'b01) begin nflag = 0; np = M_LOAD; end
      else begin nc[0] = 1'b0; np = M_IDLE; end
    end
    if (w && a == 2'd0) begin nc = d[3:0]; nflag = 0; end
    if (w && a == 2'd1) begin m_preset = d; nflag = 0; end
    m_phase = np; m_ctrl = nc; m_count = ncount; m_flag = nflag;
  endfunction

  function automatic logic [31:0] model_dout(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) model_step(reset, we, addr, din);

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("model_dout", dout, model_dout(addr));
      check("model_irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic irq_chk(input string name, input bit exp);
    check(name, 32'(irq), 32'(exp));
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = '0;
    tick(2);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state
    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_preset", 2'd1, 32'd0);
    rd_chk("rst_count", 2'd2, 32'd0);
    irq_chk("rst_irq", 1'b0);

    // Reset wins over a simultaneous write
    reset = 1'b1; we = 1'b1; addr = 2'd1; din = 32'd5;
    cyc();
    reset = 1'b0; we = 1'b0;
    rd_chk("rst_beats_we", 2'd1, 32'd0);

    // One-shot, P = 5
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(2);
    rd_chk("os_count_e2", 2'd2, 32'd5);
    tick(4);
    irq_chk("os_irq_e6", 1'b0);
    tick(1);
    rd_chk("os_count_e7", 2'd2, 32'd0);
    irq_chk("os_irq_e7", 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      irq_chk("os_irq_sticky", 1'b1);
    end
    rd_chk("os_ctrl_en_clr", 2'd0, 32'h8);
    wr(2'd0, 32'h8);
    irq_chk("os_irq_cleared", 1'b0);

    // Auto-reload, P = 3: pulses after E5, E10, E15
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      irq_chk("ar_pulse", (k % 5) == 0);
    end
    wr(2'd0, 32'h0);

    // Masked expiry
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      irq_chk("mask_irq", 1'b0);
    end
    rd_chk("mask_count", 2'd2, 32'd0);
    rd_chk("mask_en_clr", 2'd0, 32'd0);
    wr(2'd0, 32'h8);
    irq_chk("mask_unmask_irq", 1'b0);
    tick(1);
    irq_chk("mask_unmask_irq2", 1'b0);

    // Pause and resume
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    tick(2);
    rd_chk("pause_count_e2", 2'd2, 32'd10);
    tick(3);
    rd_chk("pause_count_e5", 2'd2, 32'd7);
    wr(2'd0, 32'h0);
    tick(3);
    rd_chk("pause_hold", 2'd2, 32'd6);
    wr(2'd0, 32'h1);
    tick(1);
    rd_chk("resume_e1", 2'd2, 32'd6);
    tick(1);
    rd_chk("resume_reload", 2'd2, 32'd10);

    // PRESET 0 and 1 both expire after E3
    for (int p = 0; p < 2; p++) begin
      do_reset();
      wr(2'd1, 32'(p));
      wr(2'd0, 32'h9);
      tick(2);
      irq_chk("p01_irq_e2", 1'b0);
      tick(1);
      irq_chk("p01_irq_e3", 1'b1);
      rd_chk("p01_count_e3", 2'd2, 32'd0);
    end

    // PRESET write mid-count only takes effect at the next reload
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'hB);
    tick(2);
    rd_chk("mid_count_e2", 2'd2, 32'd4);
    wr(2'd1, 32'd100);
    tick(2);
    rd_chk("mid_count_e5", 2'd2, 32'd1);
    tick(1);
    irq_chk("mid_irq_e6", 1'b1);
    tick(2);
    rd_chk("mid_reload_100", 2'd2, 32'd100);
    rd_chk("mid_preset", 2'd1, 32'd100);

    // Writes to COUNT/reserved ignored; upper CTRL bits not stored
    wr(2'd0, 32'h0);
    tick(1);
    wr(2'd2, 32'h55);
    wr(2'd3, 32'hAA);
    rd_chk("count_ro", 2'd2, 32'd99);
    rd_chk("rsvd_zero", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFF0);
    rd_chk("ctrl_upper", 2'd0, 32'd0);

    // CTRL write in the same cycle as one-shot INT: written En wins
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    tick(4);
    irq_chk("race_irq_e4", 1'b1);
    wr(2'd0, 32'h9);
    rd_chk("race_ctrl", 2'd0, 32'h9);
    irq_chk("race_irq_clr", 1'b0);
    tick(2);
    rd_chk("race_restart", 2'd2, 32'd2);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom % 250) == 0;
      we    = ($urandom % 4) == 0;
      addr  = 2'($urandom);
      case (addr)
        2'd1:    din = (($urandom % 16) == 0) ? 32'($urandom % 40) : 32'($urandom % 7);
        default: din = $urandom;
      endcase
      cyc();
    end
    reset = 1'b0; we = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_irq_source.md
# timer_irq_source

Programmable down-counting timer peripheral, memory-mapped behind the system bridge, that generates the hardware interrupt request consumed by the coprocessor-0 interrupt inputs (one `HWInt` bit). Software programs a preset value and mode through three word registers. The block counts down once per clock and raises `irq` on expiry, either as a sticky level (one-shot mode) or as a single-cycle pulse (auto-reload mode).

## Interface
- `WIDTH`: default 32. Width of the PRESET and COUNT registers and of the data bus.
- `clk` in 1: system clock. All state updates on rising edge.
- `reset` in 1: synchronous, active-high. Clears all state.
- `addr` in 2: word select, the bridge's `addr[3:2]`. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` in 1: write enable, sampled on the rising edge.
- `din` in WIDTH: write data.
- `dout` out WIDTH: read data. Combinational from `addr`.
- `irq` out 1: interrupt request to one `HWInt` bit. Registered.

## Operation
- CTRL register: bit0 `En`, bits2:1 `Mode`, bit3 `IM` (irq mask). Bits 31:4 are stored as 0 and read as 0.
  - `Mode` 00 = one-shot, 01 = auto-reload. Modes 10/11 are reserved and behave as 00.
- PRESET: read/write, full WIDTH.
- COUNT: read-only. Writes to addr 2 and addr 3 are ignored. Reads of addr 3 return 0.
- Internal `flag` register. `irq = flag & IM`, driven from registers only.
- FSM states: IDLE, LOAD, CNT, INT. Reset state is IDLE.
  - IDLE: if `En` = 1, go to LOAD. Otherwise stay.
  - LOAD: COUNT <= PRESET. Go to CNT.
  - CNT, with `En` = 0: go to IDLE. COUNT holds.
  - CNT, with `En` = 1 and COUNT <= 1: COUNT <= 0, `flag` <= 1, go to INT.
  - CNT, all other cases: COUNT <= COUNT - 1.
  - INT, Mode 00: `En` <= 0, go to IDLE. `flag` stays set.
  - INT, Mode 01: `flag` <= 0, go to LOAD.
- A write to CTRL or PRESET clears `flag`, which deasserts `irq` on the next edge.
- A bus write has priority over an FSM update to the same register in the same cycle. Case: a CTRL write in the same cycle as a one-shot INT clearing `En`; the written `En` value wins.
- A PRESET write during CNT does not affect COUNT until the next LOAD.
- Clearing `En` in any state: the FSM returns to IDLE at its next transition point, via CNT's `En` check or IDLE's hold. COUNT retains its value. `flag` is cleared by the CTRL write itself.
- PRESET = 0 behaves identically to PRESET = 1: one CNT cycle, then INT.
- Arithmetic is unsigned. COUNT never wraps below 0.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, `flag` = 0, `irq` = 0, state = IDLE.
  - `dout` therefore reads 0 for every `addr`.
- Reset mid-count wins over everything, including a simultaneous `we`.
- Write of `En` = 1 at edge E0, with PRESET = P >= 1:
  - E1: IDLE -> LOAD.
  - E2: COUNT = P, state = CNT.
  - E2+k: COUNT = P-k, for k < P.
  - E2+P: COUNT = 0, state = INT, `flag` = 1. `irq` is high after edge E0+P+2 if IM = 1.
- One-shot mode: `irq` remains high until CTRL or PRESET is written. `En` reads 0 after edge E0+P+3.
- Auto-reload mode:
  - `irq` is high for exactly 1 cycle per period.
  - Period = P+2 cycles: LOAD + P CNT cycles + INT.
  - The next expiry is P+2 cycles after the previous one.
- `dout` reflects a register write from the cycle after the write edge. There is no read latency.

## Test plan
- Reset then read: assert `reset` 1 cycle, read addr 0/1/2 -> `dout` = 0 for each, `irq` = 0.
- One-shot: PRESET = 5, CTRL = 0x9 (En, IM, mode 00) at E0 -> COUNT reads 5 after E2, 0 after E7. `irq` rises after E7 and stays high for 20 idle cycles. CTRL reads 0x8. Writing CTRL = 0x8 drops `irq` after the next edge.
- Auto-reload: PRESET = 3, CTRL = 0xB -> `irq` single-cycle pulses after E5, E10, E15, with a 5-cycle period.
- Mask: PRESET = 2, CTRL = 0x1 (IM = 0) -> `irq` stays 0 throughout, although COUNT reaches 0 and `En` clears after E5. Then write CTRL = 0x8 -> `irq` stays 0, because the write clears `flag`.
- Pause: PRESET = 10, enable, write CTRL `En` = 0 when COUNT = 6 -> COUNT holds at 6 and the state returns to IDLE. Re-enabling reloads COUNT to 10 two edges later.
- Edge cases:
  - PRESET = 0 expires on the same cycle as PRESET = 1.
  - A PRESET write of 100 mid-count leaves the current countdown unchanged; the next auto-reload loads 100.
  - A write to addr 2 is ignored.
